// File: rtl/rc_pwm_pkg.sv
// rc_pwm_pkg: shared constants, FSM state types and helpers
// for the rc_pwm_axil register block and its PWM core.
package rc_pwm_pkg;

  localparam logic [4:0] ADDR_CTRL   = 5'h00;
  localparam logic [4:0] ADDR_PERIOD = 5'h04;
  localparam logic [4:0] ADDR_DUTY   = 5'h08;
  localparam logic [4:0] ADDR_DT     = 5'h0C;
  localparam logic [4:0] ADDR_STATUS = 5'h10;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam int EN_BIT     = 0;
  localparam int STAT_CNT_W = 16;

  typedef enum logic {
    WR_IDLE,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_t;

  function automatic logic [31:0] apply_strb(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  strb
  );
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++)
      if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/rc_pwm_core.sv
// rc_pwm_core: shadowed period/duty/deadtime, period counter and
// registered complementary gate drive. in: en, period, duty,
// deadtime. out: pwm_h, pwm_l, running, period_count.
module rc_pwm_core
  import rc_pwm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [CNT_W-1:0]      period,
  input  logic [CNT_W-1:0]      duty,
  input  logic [CNT_W-1:0]      deadtime,
  output logic                  pwm_h,
  output logic                  pwm_l,
  output logic                  running,
  output logic [STAT_CNT_W-1:0] period_count
);

  logic             en_q;
  logic [CNT_W-1:0] p_q;
  logic [CNT_W-1:0] d_q;
  logic [CNT_W-1:0] t_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   dt_sum;
  logic             h_t;
  logic             l_t;
  logic             wrap;
  logic             load;

  assign running = en_q && (p_q >= CNT_W'(2));
  assign dt_sum  = {1'b0, d_q} + {1'b0, t_q};
  assign h_t     = (cnt >= t_q) && (cnt < d_q);
  assign l_t     = ({1'b0, cnt} >= dt_sum)
                && (cnt < p_q);
  assign wrap    = running
                && (cnt == p_q - CNT_W'(1));
  // Shadows track the registers every cycle while
  // stalled (first enabled cycle or P < 2), so a new
  // PERIOD takes effect without toggling EN.
  assign load    = !running || wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q         <= 1'b0;
      cnt          <= '0;
      p_q          <= '0;
      d_q          <= '0;
      t_q          <= '0;
      pwm_h        <= 1'b0;
      pwm_l        <= 1'b0;
      period_count <= '0;
    end else if (!en) begin
      en_q         <= 1'b0;
      cnt          <= '0;
      pwm_h        <= 1'b0;
      pwm_l        <= 1'b0;
      period_count <= '0;
    end else begin
      en_q  <= 1'b1;
      pwm_h <= running && h_t;
      pwm_l <= running && l_t;
      if (load) begin
        p_q <= period;
        d_q <= duty;
        t_q <= deadtime;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if (wrap)
        period_count <= period_count
                      + STAT_CNT_W'(1);
    end
  end

  a_no_overlap: assert property (
    @(posedge clk) disable iff (rst)
    !(pwm_h && pwm_l)
  );

endmodule

// File: rtl/rc_pwm_axil.sv
// rc_pwm_axil: AXI4-Lite slave with CTRL/PERIOD/DUTY/DEADTIME/STATUS
// registers driving rc_pwm_core. ports: s00_axi_* slave, pwm_h/pwm_l.
module rc_pwm_axil
  import rc_pwm_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int CNT_W              = 16
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic                            pwm_h,
  output logic                            pwm_l
);

  wr_state_t wr_st, wr_nx;
  rd_state_t rd_st, rd_nx;

  logic                  wr_hs;
  logic                  rd_hs;
  logic [4:0]            wa;
  logic [4:0]            ra;
  logic [31:0]           ctrl_q;
  logic [31:0]           period_q;
  logic [31:0]           duty_q;
  logic [31:0]           dt_q;
  logic [31:0]           status;
  logic [31:0]           rd_mux;
  logic                  running;
  logic [STAT_CNT_W-1:0] pcnt;
  logic                  unused_ok;

  assign unused_ok = ^{s00_axi_awprot,
                       s00_axi_arprot,
                       s00_axi_awaddr[1:0],
                       s00_axi_araddr[1:0]};

  assign wa = {s00_axi_awaddr[4:2], 2'b00};
  assign ra = {s00_axi_araddr[4:2], 2'b00};

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      wr_st <= WR_IDLE;
      rd_st <= RD_IDLE;
    end else begin
      wr_st <= wr_nx;
      rd_st <= rd_nx;
    end
  end

  always_comb begin
    wr_nx = wr_st;
    rd_nx = rd_st;
    unique case (wr_st)
      WR_IDLE:
        if (s00_axi_awvalid && s00_axi_wvalid)
          wr_nx = WR_RESP;
      WR_RESP:
        if (s00_axi_bready) wr_nx = WR_IDLE;
    endcase
    unique case (rd_st)
      RD_IDLE:
        if (s00_axi_arvalid) rd_nx = RD_DATA;
      RD_DATA:
        if (s00_axi_rready) rd_nx = RD_IDLE;
    endcase
  end

  // Ready is combinational so the register lands on
  // the same edge that completes the handshake.
  always_comb begin
    wr_hs = !s00_axi_areset
         && (wr_st == WR_IDLE)
         && s00_axi_awvalid
         && s00_axi_wvalid;
    rd_hs = !s00_axi_areset
         && (rd_st == RD_IDLE)
         && s00_axi_arvalid;
    s00_axi_awready = wr_hs;
    s00_axi_wready  = wr_hs;
    s00_axi_arready = rd_hs;
    s00_axi_bvalid  = (wr_st == WR_RESP);
    s00_axi_rvalid  = (rd_st == RD_DATA);
    s00_axi_bresp   = RESP_OKAY;
    s00_axi_rresp   = RESP_OKAY;
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      ctrl_q   <= '0;
      period_q <= '0;
      duty_q   <= '0;
      dt_q     <= '0;
    end else if (wr_hs) begin
      unique case (1'b1)
        (wa == ADDR_CTRL):
          ctrl_q <= apply_strb(ctrl_q,
            s00_axi_wdata, s00_axi_wstrb);
        (wa == ADDR_PERIOD):
          period_q <= apply_strb(period_q,
            s00_axi_wdata, s00_axi_wstrb);
        (wa == ADDR_DUTY):
          duty_q <= apply_strb(duty_q,
            s00_axi_wdata, s00_axi_wstrb);
        (wa == ADDR_DT):
          dt_q <= apply_strb(dt_q,
            s00_axi_wdata, s00_axi_wstrb);
        default: ;
      endcase
    end
  end

  assign status = {pcnt, 13'd0,
                   pwm_l, pwm_h, running};

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      (ra == ADDR_CTRL):   rd_mux = ctrl_q;
      (ra == ADDR_PERIOD): rd_mux = period_q;
      (ra == ADDR_DUTY):   rd_mux = duty_q;
      (ra == ADDR_DT):     rd_mux = dt_q;
      (ra == ADDR_STATUS): rd_mux = status;
      default:             rd_mux = '0;
    endcase
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset)
      s00_axi_rdata <= '0;
    else if (rd_hs)
      s00_axi_rdata <= rd_mux;
  end

  rc_pwm_core #(
    .CNT_W(CNT_W)
  ) u_core (
    .clk         (s00_axi_aclk),
    .rst         (s00_axi_areset),
    .en          (ctrl_q[EN_BIT]),
    .period      (period_q[CNT_W-1:0]),
    .duty        (duty_q[CNT_W-1:0]),
    .deadtime    (dt_q[CNT_W-1:0]),
    .pwm_h       (pwm_h),
    .pwm_l       (pwm_l),
    .running     (running),
    .period_count(pcnt)
  );

endmodule

// File: tb/tb_rc_pwm_axil.sv
// tb_rc_pwm_axil: directed and randomized bench for rc_pwm_axil,
// with a cycle-level reference model of the registers and PWM.
module tb_rc_pwm_axil;

  logic        tb_ACLK = 1'b0;
  logic        areset;
  logic [4:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [4:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        pwm_h;
  logic        pwm_l;

  always #5 tb_ACLK = ~tb_ACLK;

  rc_pwm_axil #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(5),
    .CNT_W(16)
  ) dut (
    .s00_axi_aclk   (tb_ACLK),
    .s00_axi_areset (areset),
    .s00_axi_awaddr (awaddr),
    .s00_axi_awprot (awprot),
    .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready),
    .s00_axi_wdata  (wdata),
    .s00_axi_wstrb  (wstrb),
    .s00_axi_wvalid (wvalid),
    .s00_axi_wready (wready),
    .s00_axi_bresp  (bresp),
    .s00_axi_bvalid (bvalid),
    .s00_axi_bready (bready),
    .s00_axi_araddr (araddr),
    .s00_axi_arprot (arprot),
    .s00_axi_arvalid(arvalid),
    .s00_axi_arready(arready),
    .s00_axi_rdata  (rdata),
    .s00_axi_rresp  (rresp),
    .s00_axi_rvalid (rvalid),
    .s00_axi_rready (rready),
    .pwm_h          (pwm_h),
    .pwm_l          (pwm_l)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_reg [4];
  logic [31:0] m_rdata = '0;
  bit m_wr_busy = 0, m_rd_busy = 0;
  bit m_w_acc = 0, m_r_acc = 0;
  bit m_on = 0, m_h = 0, m_l = 0, m_run;
  bit w_go, r_go;
  int m_cnt = 0, m_P = 0, m_D = 0, m_T = 0;
  int m_count = 0;

  function automatic logic [31:0] m_status();
    logic [15:0] c;
    c = 16'(m_count);
    return {c, 13'd0, m_l, m_h,
            (m_on && m_P >= 2)};
  endfunction

  function automatic logic [31:0] m_read(
    input logic [4:0] a);
    case (a[4:2])
      3'd0, 3'd1, 3'd2, 3'd3: return m_reg[a[3:2]];
      3'd4: return m_status();
      default: return 32'd0;
    endcase
  endfunction

  initial for (int i = 0; i < 4; i++) m_reg[i] = '0;

  always @(posedge tb_ACLK) begin
    m_w_acc = 0;
    m_r_acc = 0;
    if (areset) begin
      for (int i = 0; i < 4; i++) m_reg[i] = '0;
      m_rdata = '0;
      m_wr_busy = 0; m_rd_busy = 0;
      m_on = 0; m_h = 0; m_l = 0;
      m_cnt = 0; m_P = 0; m_D = 0; m_T = 0;
      m_count = 0;
    end else begin
      r_go = !m_rd_busy && arvalid;
      w_go = !m_wr_busy && awvalid && wvalid;
      // read sees state from before this edge
      if (r_go) m_rdata = m_read(araddr);
      // PWM: outputs describe the count of the
      // previous cycle; shadows refresh at period end
      if (!m_reg[0][0]) begin
        m_on = 0; m_cnt = 0; m_count = 0;
        m_h = 0; m_l = 0;
      end else begin
        m_run = m_on && (m_P >= 2);
        m_h = m_run && m_cnt >= m_T && m_cnt < m_D;
        m_l = m_run && m_cnt >= m_D + m_T
                    && m_cnt < m_P;
        if (!m_run || m_cnt == m_P - 1) begin
          if (m_run) m_count = (m_count + 1) % 65536;
          m_P = int'(m_reg[1][15:0]);
          m_D = int'(m_reg[2][15:0]);
          m_T = int'(m_reg[3][15:0]);
          m_cnt = 0;
        end else begin
          m_cnt = m_cnt + 1;
        end
        m_on = 1;
      end
      if (w_go && awaddr[4] == 1'b0)
        for (int b = 0; b < 4; b++)
          if (wstrb[b])
            m_reg[awaddr[3:2]][8*b +: 8] =
              wdata[8*b +: 8];
      if (w_go) m_wr_busy = 1;
      else if (bready) m_wr_busy = 0;
      if (r_go) m_rd_busy = 1;
      else if (rready) m_rd_busy = 0;
      m_w_acc = w_go;
      m_r_acc = r_go;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge tb_ACLK) begin
    chk("pwm_h", pwm_h, m_h);
    chk("pwm_l", pwm_l, m_l);
    chk("overlap", pwm_h & pwm_l, 0);
    chk("awready", awready,
        !areset && !m_wr_busy && awvalid && wvalid);
    chk("wready", wready,
        !areset && !m_wr_busy && awvalid && wvalid);
    chk("arready", arready,
        !areset && !m_rd_busy && arvalid);
    chk("bvalid", bvalid, m_wr_busy);
    chk("rvalid", rvalid, m_rd_busy);
    chk("rdata", rdata, m_rdata);
    chk("bresp", bresp, 0);
    chk("rresp", rresp, 0);
  end

  // ---------------- directed helpers ----------------
  task automatic axi_write(input logic [4:0] a,
                           input logic [31:0] d,
                           input logic [3:0] s,
                           output logic [1:0] r);
    int n;
    @(posedge tb_ACLK); #1;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1; wvalid = 1;
    n = 0;
    @(negedge tb_ACLK);
    while (!awready && n < 50) begin
      @(negedge tb_ACLK); n++;
    end
    if (!awready) chk("aw_timeout", awready, 1);
    @(posedge tb_ACLK); #1;
    awvalid = 0; wvalid = 0;
    n = 0;
    @(negedge tb_ACLK);
    while (!bvalid && n < 50) begin
      @(negedge tb_ACLK); n++;
    end
    if (!bvalid) chk("b_timeout", bvalid, 1);
    r = bresp;
    @(posedge tb_ACLK);
  endtask

  task automatic axi_read(input logic [4:0] a,
                          output logic [31:0] d,
                          output logic [1:0] r);
    int n;
    @(posedge tb_ACLK); #1;
    araddr = a; arvalid = 1;
    n = 0;
    @(negedge tb_ACLK);
    while (!arready && n < 50) begin
      @(negedge tb_ACLK); n++;
    end
    if (!arready) chk("ar_timeout", arready, 1);
    @(posedge tb_ACLK); #1;
    arvalid = 0;
    n = 0;
    @(negedge tb_ACLK);
    while (!rvalid && n < 50) begin
      @(negedge tb_ACLK); n++;
    end
    if (!rvalid) chk("r_timeout", rvalid, 1);
    d = rdata; r = rresp;
    @(posedge tb_ACLK);
  endtask

  task automatic window(input int n,
                        output int hc, output int lc);
    hc = 0; lc = 0;
    repeat (n) begin
      @(negedge tb_ACLK);
      hc += int'(pwm_h);
      lc += int'(pwm_l);
    end
  endtask

  task automatic wait_ready(input bit is_aw);
    int n;
    n = 0;
    @(negedge tb_ACLK);
    while ((is_aw ? !awready : !arready) && n < 20) begin
      @(negedge tb_ACLK); n++;
    end
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] t1 [4];
  logic [31:0] d;
  logic [1:0]  rs;
  int          hc, lc, slot;
  bit          found;

  initial begin
    t1[0] = 32'h0101FFFF; t1[1] = 32'habcd0001;
    t1[2] = 32'hdead0011; t1[3] = 32'hbeef0011;
    areset = 1; awaddr = '0; awprot = '0;
    awvalid = 0; wdata = '0; wstrb = '0;
    wvalid = 0; bready = 1; araddr = '0;
    arprot = '0; arvalid = 0; rready = 1;
    repeat (3) @(posedge tb_ACLK);
    #1 areset = 0;
    @(negedge tb_ACLK);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_pwm", {pwm_h, pwm_l}, 0);

    // 1: four-vector write/readback
    for (int i = 0; i < 4; i++) begin
      axi_write(5'(i * 4), t1[i], 4'hF, rs);
      chk("t1_bresp", rs, 0);
      axi_read(5'(i * 4), d, rs);
      chk("t1_rd", d, t1[i]);
      chk("t1_rresp", rs, 0);
    end

    // 2: byte strobes, RO and unmapped writes
    axi_write(5'h04, 32'h0, 4'hF, rs);
    axi_write(5'h04, 32'hFFFFFFFF, 4'b0101, rs);
    axi_read(5'h04, d, rs);
    chk("t2_strb", d, 32'h00FF00FF);
    axi_write(5'h00, 32'h0, 4'hF, rs);
    repeat (3) @(posedge tb_ACLK);
    axi_write(5'h10, 32'h12345678, 4'hF, rs);
    chk("t2_ro_bresp", rs, 0);
    axi_read(5'h10, d, rs);
    chk("t2_status", d, 32'h0);
    axi_write(5'h14, 32'hCAFEF00D, 4'hF, rs);
    chk("t2_unmap_bresp", rs, 0);
    axi_read(5'h14, d, rs);
    chk("t2_unmap_rd", d, 32'h0);

    // 3: P=10 D=5 T=1
    axi_write(5'h04, 32'd10, 4'hF, rs);
    axi_write(5'h08, 32'd5, 4'hF, rs);
    axi_write(5'h0C, 32'd1, 4'hF, rs);
    axi_write(5'h00, 32'd1, 4'hF, rs);
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      axi_read(5'h10, d, rs);
      if (d[31:16] >= 16'd3) found = 1;
    end
    chk("t3_found", 32'(found), 1);
    chk("t3_count", 32'(d[31:16]), 3);
    chk("t3_running", 32'(d[0]), 1);
    window(10, hc, lc);
    chk("t3_h_cycles", hc, 4);
    chk("t3_l_cycles", lc, 4);

    // 4: duty change lands on the next period
    axi_write(5'h08, 32'd8, 4'hF, rs);
    repeat (25) @(posedge tb_ACLK);
    window(10, hc, lc);
    chk("t4_h_cycles", hc, 7);
    chk("t4_l_cycles", lc, 1);

    // 5: P<2 stops, then D >= P
    axi_write(5'h04, 32'd1, 4'hF, rs);
    repeat (15) @(posedge tb_ACLK);
    window(10, hc, lc);
    chk("t5_idle_h", hc, 0);
    chk("t5_idle_l", lc, 0);
    axi_read(5'h10, d, rs);
    chk("t5_running", 32'(d[0]), 0);
    axi_write(5'h08, 32'd20, 4'hF, rs);
    axi_write(5'h04, 32'd10, 4'hF, rs);
    repeat (15) @(posedge tb_ACLK);
    window(10, hc, lc);
    chk("t5_full_h", hc, 9);
    chk("t5_full_l", lc, 0);

    // 6: bready backpressure, then reset mid-read
    bready = 0;
    @(posedge tb_ACLK); #1;
    awaddr = 5'h0C; wdata = 32'd1; wstrb = 4'hF;
    awvalid = 1; wvalid = 1;
    wait_ready(1);
    chk("t6_aw1", awready, 1);
    @(posedge tb_ACLK); #1;
    awaddr = 5'h08; wdata = 32'd8;
    for (int i = 0; i < 5; i++) begin
      @(negedge tb_ACLK);
      chk("t6_bvalid_hold", bvalid, 1);
      chk("t6_aw_blocked", awready, 0);
    end
    @(posedge tb_ACLK); #1;
    bready = 1;
    wait_ready(1);
    chk("t6_aw2", awready, 1);
    @(posedge tb_ACLK); #1;
    awvalid = 0; wvalid = 0;
    repeat (3) @(posedge tb_ACLK);
    #1 rready = 0;
    araddr = 5'h08; arvalid = 1;
    wait_ready(0);
    @(posedge tb_ACLK); #1;
    arvalid = 0;
    @(negedge tb_ACLK);
    chk("t6_rvalid_pre", rvalid, 1);
    chk("t6_rdata_pre", rdata, 32'd8);
    @(posedge tb_ACLK); #1;
    areset = 1;
    @(posedge tb_ACLK); #1;
    areset = 0; rready = 1;
    @(negedge tb_ACLK);
    chk("t6_rvalid_rst", rvalid, 0);
    for (int i = 0; i < 8; i++) begin
      axi_read(5'(i * 4), d, rs);
      chk("t6_reg_zero", d, 0);
    end

    // randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      @(posedge tb_ACLK); #1;
      areset = ($urandom_range(0, 799) == 0);
      if (awvalid && m_w_acc) begin
        awvalid = 0; wvalid = 0;
      end
      if (!awvalid && $urandom_range(0, 2) == 0) begin
        slot = $urandom_range(0, 7);
        awaddr = {3'(slot), 2'($urandom)};
        if (slot == 0) begin
          wdata = $urandom;
          wdata[0] = ($urandom_range(0, 3) != 0);
        end else if (slot < 4) begin
          wdata = {16'($urandom), 8'h00,
                   8'($urandom_range(0, 24))};
        end else begin
          wdata = $urandom;
        end
        wstrb = ($urandom_range(0, 3) == 0)
              ? 4'($urandom) : 4'hF;
        awvalid = 1; wvalid = 1;
      end
      if (arvalid && m_r_acc) arvalid = 0;
      if (!arvalid && $urandom_range(0, 2) == 0) begin
        araddr = 5'($urandom);
        arvalid = 1;
      end
      bready = ($urandom_range(0, 3) != 0);
      rready = ($urandom_range(0, 3) != 0);
    end
    @(posedge tb_ACLK); #1;
    areset = 0; awvalid = 0; wvalid = 0;
    arvalid = 0; bready = 1; rready = 1;
    repeat (5) @(posedge tb_ACLK);
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
